// File: rtl/fp_pkg.sv
// Shared floating-point constants, flag positions and divider state encoding.
// Exponent constants are functions of the format widths so every FP block derives them the same way.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIV    = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } div_state_e;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int exponentBias(input int exp_bits);
    return (32'sd1 <<< (exp_bits - 1)) - 32'sd1;
  endfunction

  function automatic int minBiasedExponent(input int exp_bits);
    return (exp_bits > 0) ? 32'sd1 : 32'sd0;
  endfunction

  function automatic int maxBiasedExponent(input int exp_bits);
    return (32'sd1 <<< exp_bits) - 32'sd2;
  endfunction

  function automatic int infBiasedExponent(input int exp_bits);
    return (32'sd1 <<< exp_bits) - 32'sd1;
  endfunction

  function automatic int nanMantissa(input int mant_bits);
    return 32'sd1 <<< (mant_bits - 1);
  endfunction

endpackage

// File: rtl/zeroMSBCounter.sv
// Counts leading zeros of an N-bit word; an all-zero word returns N.
module zeroMSBCounter #(
  parameter int N = 24
) (
  input  logic [N-1:0]             i_value,
  output logic [$clog2(N+1)-1:0]   o_count
);
  localparam int CW = $clog2(N + 1);

  logic w_found;

  // Scan from the MSB and stop counting at the first set bit.
  always_comb begin
    o_count = '0;
    w_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_found) begin
        w_found = 1'b1;
      end else if (i_value[i]) begin
        w_found = 1'b1;
      end else begin
        o_count = o_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 divider (x / y): one restoring quotient bit per cycle,
// round-to-nearest-even, valid/ready handshakes on both sides.
module fp_divider_iter
  import fp_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] x,
  input  logic [BITS-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out,
  output logic [4:0]      flags
);
  localparam int M    = MANTISSA_BITS;
  localparam int E    = EXPONENT_BITS;
  localparam int MN   = M + 1;
  localparam int QW   = M + 3;
  localparam int EW   = E + 2;
  localparam int CW   = $clog2(MN + 1);
  localparam int CNTW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS   = EW'(exponentBias(E));
  localparam logic signed [EW-1:0] MIN_E  = EW'(minBiasedExponent(E));
  localparam logic signed [EW-1:0] INF_E  = EW'(infBiasedExponent(E));
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] QW_S   = EW'(QW);
  localparam logic [E-1:0]         EXP_ONES = {E{1'b1}};
  localparam logic [M-1:0]         NAN_MANT = M'(nanMantissa(M));
  localparam logic [CNTW-1:0]      CNT_INIT = CNTW'(QW - 1);

  div_state_e              r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [BITS-1:0]         r_out;
  logic [4:0]              r_flags;
  logic [BITS-1:0]         r_x;
  logic [BITS-1:0]         r_y;
  logic                    r_sign;
  logic signed [EW-1:0]    r_ez;
  logic [QW-1:0]           r_rem;
  logic [MN-1:0]           r_my;
  logic [QW-1:0]           r_q;
  logic [CNTW-1:0]         r_cnt;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign flags     = r_flags;

  // ---------------- unpack ----------------
  logic [E-1:0]         w_xe, w_ye;
  logic [M-1:0]         w_xf, w_yf;
  logic                 w_xe_zero, w_ye_zero, w_xe_ones, w_ye_ones;
  logic                 w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
  logic [MN-1:0]        w_xm, w_ym, w_xm_norm, w_ym_norm;
  logic [CW-1:0]        w_x_lz, w_y_lz;
  logic signed [EW-1:0] w_x_exp, w_y_exp, w_ez;
  logic                 w_sign;

  assign w_xe      = r_x[BITS-2:M];
  assign w_ye      = r_y[BITS-2:M];
  assign w_xf      = r_x[M-1:0];
  assign w_yf      = r_y[M-1:0];
  assign w_xe_zero = (w_xe == '0);
  assign w_ye_zero = (w_ye == '0);
  assign w_xe_ones = (w_xe == EXP_ONES);
  assign w_ye_ones = (w_ye == EXP_ONES);
  assign w_x_nan   = w_xe_ones && (w_xf != '0);
  assign w_y_nan   = w_ye_ones && (w_yf != '0);
  assign w_x_inf   = w_xe_ones && (w_xf == '0);
  assign w_y_inf   = w_ye_ones && (w_yf == '0);
  assign w_x_zero  = w_xe_zero && (w_xf == '0);
  assign w_y_zero  = w_ye_zero && (w_yf == '0);
  assign w_sign    = r_x[BITS-1] ^ r_y[BITS-1];
  assign w_xm      = {~w_xe_zero, w_xf};
  assign w_ym      = {~w_ye_zero, w_yf};

  zeroMSBCounter #(.N(MN)) u_lzc_x (.i_value(w_xm), .o_count(w_x_lz));
  zeroMSBCounter #(.N(MN)) u_lzc_y (.i_value(w_ym), .o_count(w_y_lz));

  assign w_xm_norm = w_xm << w_x_lz;
  assign w_ym_norm = w_ym << w_y_lz;
  assign w_x_exp   = (w_xe_zero ? MIN_E : $signed({2'b00, w_xe})) - $signed({{(EW-CW){1'b0}}, w_x_lz});
  assign w_y_exp   = (w_ye_zero ? MIN_E : $signed({2'b00, w_ye})) - $signed({{(EW-CW){1'b0}}, w_y_lz});
  assign w_ez      = w_x_exp - w_y_exp + BIAS;

  logic            w_spec;
  logic [BITS-1:0] w_spec_out;
  logic [4:0]      w_spec_flags;

  // Special operands bypass the iteration; order matters (NaN-producing cases first).
  always_comb begin
    w_spec       = 1'b1;
    w_spec_out   = '0;
    w_spec_flags = 5'b00000;
    if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
      w_spec_out                 = {1'b0, EXP_ONES, NAN_MANT};
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_x_inf) begin
      w_spec_out = {w_sign, EXP_ONES, {M{1'b0}}};
    end else if (w_y_zero) begin
      w_spec_out                 = {w_sign, EXP_ONES, {M{1'b0}}};
      w_spec_flags[FLAG_DIVZERO] = 1'b1;
    end else if (w_y_inf || w_x_zero) begin
      w_spec_out = {w_sign, {(BITS-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // ---------------- divide step ----------------
  logic          w_ge;
  logic [QW-1:0] w_trial;

  assign w_ge    = (r_rem >= {2'b00, r_my});
  assign w_trial = r_rem - {2'b00, r_my};

  // ---------------- round ----------------
  logic [QW-1:0]        w_qn, w_qs;
  logic signed [EW-1:0] w_ezn, w_diff, w_epre, w_efin;
  logic [EW-1:0]        w_shamt;
  logic                 w_tiny, w_lost, w_sticky, w_g, w_rb, w_inc, w_hid, w_inexact, w_ovf;
  logic [MN-1:0]        w_mant;
  logic [MN:0]          w_sum;
  logic [M-1:0]         w_frac;
  logic [BITS-1:0]      w_round_out;
  logic [4:0]           w_round_flags;

  // Normalise, denormalise if tiny, then round-to-nearest-even.
  always_comb begin
    if (!r_q[QW-1]) begin
      w_qn  = r_q << 1;
      w_ezn = r_ez - ONE_E;
    end else begin
      w_qn  = r_q;
      w_ezn = r_ez;
    end
    w_tiny  = (w_ezn < MIN_E);
    w_diff  = MIN_E - w_ezn;
    w_shamt = '0;
    if (w_tiny) begin
      if (w_diff > QW_S) begin
        w_shamt = EW'(QW);
      end else begin
        w_shamt = $unsigned(w_diff);
      end
    end else begin
      w_shamt = '0;
    end
    w_qs     = w_qn >> w_shamt;
    w_lost   = |(w_qn & ~({QW{1'b1}} << w_shamt));
    w_sticky = (r_rem != '0) | w_lost;
    w_epre   = w_tiny ? MIN_E : w_ezn;
    w_mant   = w_qs[QW-1:2];
    w_g      = w_qs[1];
    w_rb     = w_qs[0];
    w_inc    = w_g & (w_rb | w_sticky | w_mant[0]);
    w_sum    = {1'b0, w_mant} + {{MN{1'b0}}, w_inc};
    if (w_sum[MN]) begin
      w_efin = w_epre + ONE_E;
      w_frac = w_sum[M:1];
      w_hid  = 1'b1;
    end else begin
      w_efin = w_epre;
      w_frac = w_sum[M-1:0];
      w_hid  = w_sum[M];
    end
    w_inexact     = w_g | w_rb | w_sticky;
    w_ovf         = (w_ezn >= INF_E) || (w_efin >= INF_E);
    w_round_flags = 5'b00000;
    if (w_ovf) begin
      w_round_out                    = {r_sign, EXP_ONES, {M{1'b0}}};
      w_round_flags[FLAG_OVERFLOW]   = 1'b1;
      w_round_flags[FLAG_INEXACT]    = 1'b1;
    end else begin
      w_round_out                    = {r_sign, (w_hid ? w_efin[E-1:0] : {E{1'b0}}), w_frac};
      w_round_flags[FLAG_UNDERFLOW]  = w_tiny & w_inexact;
      w_round_flags[FLAG_INEXACT]    = w_inexact;
    end
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= 5'b00000;
      r_x         <= '0;
      r_y         <= '0;
      r_sign      <= 1'b0;
      r_ez        <= '0;
      r_rem       <= '0;
      r_my        <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= x;
            r_y        <= y;
            r_in_ready <= 1'b0;
            r_state    <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          r_sign <= w_sign;
          if (w_spec) begin
            r_out       <= w_spec_out;
            r_flags     <= w_spec_flags;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_rem   <= {2'b00, w_xm_norm};
            r_my    <= w_ym_norm;
            r_ez    <= w_ez;
            r_q     <= '0;
            r_cnt   <= CNT_INIT;
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          r_q   <= {r_q[QW-2:0], w_ge};
          r_rem <= (w_ge ? w_trial : r_rem) << 1;
          if (r_cnt == '0) begin
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        ST_ROUND: begin
          r_out       <= w_round_out;
          r_flags     <= w_round_flags;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_iter.sv
// Directed-vector bench for fp_divider_iter: table of operands with hand-computed
// results, plus backpressure and mid-operation reset sequences.
module tb_fp_divider_iter;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  fp_divider_iter #(.BITS(32), .MANTISSA_BITS(23), .EXPONENT_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_accept(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    x        = a;
    y        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit busy_bad);
    lat      = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) busy_bad = 1'b1;
    end
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    bit          busy_bad;
    bit          stable_bad;
    logic [31:0] held_out;
    logic [4:0]  held_fl;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1};
    vecs[3]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 5'h10, 1};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'h10, 1};
    vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00400000, 5'h00, 28};
    vecs[6]  = '{32'h00000001, 32'h40000000, 32'h00000000, 5'h03, 28};
    vecs[7]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 28};
    vecs[8]  = '{32'hC0000000, 32'h40000000, 32'hBF800000, 5'h00, 28};
    vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 5'h00, 1};
    vecs[10] = '{32'h40000000, 32'h7F800000, 32'h00000000, 5'h00, 1};
    vecs[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 5'h00, 1};
    vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'h10, 1};
    vecs[13] = '{32'h00400000, 32'h3F000000, 32'h00800000, 5'h00, 28};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 32'd0;
    y         = 32'd0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_accept(vecs[i].a, vecs[i].b);
      wait_valid(lat, busy_bad);
      chk($sformatf("v%0d_out", i), out, vecs[i].q);
      chk($sformatf("v%0d_flags", i), {27'd0, flags}, {27'd0, vecs[i].fl});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_ready", i), {31'd0, busy_bad}, 32'd0);
      take_result($sformatf("v%0d", i));
    end

    // Backpressure: result must hold for 10 cycles with out_ready low.
    do_accept(32'h40C00000, 32'h40000000);
    wait_valid(lat, busy_bad);
    held_out   = out;
    held_fl    = flags;
    stable_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out !== held_out || flags !== held_fl) stable_bad = 1'b1;
    end
    chk("bp_out", out, 32'h40400000);
    chk("bp_stable", {31'd0, stable_bad}, 32'd0);
    take_result("bp");

    // Reset in the middle of the iteration aborts the operation.
    do_accept(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_accept(32'h40C00000, 32'h40000000);
    wait_valid(lat, busy_bad);
    chk("after_rst_out", out, 32'h40400000);
    chk("after_rst_flags", {27'd0, flags}, 32'd0);
    chk("after_rst_latency", lat, 28);
    take_result("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
